// File: rtl/sdm_cic3_decim.sv
// Third-order CIC (sinc^3) decimator for a 1-bit sigma-delta stream, decimating by 2^osr.
// Signed PCM leaves through a one-entry valid/ready holding register with a sticky overrun flag.
module sdm_cic3_decim #(
    parameter int unsigned osr    = 6,
    parameter int unsigned out_bw = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     in_bit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [out_bw-1:0] out_pcm,
    output logic                     ovf
);

    localparam int unsigned W  = 3 * osr + 2;
    localparam int unsigned SH = 3 * osr - out_bw + 1;
    localparam int unsigned R  = 2 ** osr;

    localparam logic signed [W-1:0] PCM_MAX = W'(2 ** (out_bw - 1) - 1);
    localparam logic signed [W-1:0] PCM_MIN = W'(-(2 ** (out_bw - 1)));

    logic [W-1:0]   i1, i2, i3;
    logic [W-1:0]   x, i1_n, i2_n, i3_n;
    logic [osr-1:0] cnt;
    logic           frame_end;
    logic [W-1:0]   dec;
    logic           strobe;

    logic [W-1:0]   d1, d2, d3;
    logic [W-1:0]   c1, c2, c3;
    logic [W-1:0]   y;
    logic           y_vld;
    logic [1:0]     warm;
    logic           load;

    logic signed [W-1:0]      y_sh;
    logic signed [out_bw-1:0] pcm_sat;

    // Integrator chain next values; the cascade settles within the accepting edge.
    always_comb begin
        x         = in_bit ? W'(1) : '1;
        i1_n      = i1 + x;
        i2_n      = i2 + i1_n;
        i3_n      = i3 + i2_n;
        frame_end = (cnt == osr'(R - 1));
    end

    // Integrators, decimation counter and frame capture advance on accepted bits only.
    always_ff @(posedge clk) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
            dec <= '0;
        end else if (in_valid) begin
            i1  <= i1_n;
            i2  <= i2_n;
            i3  <= i3_n;
            cnt <= cnt + osr'(1);
            if (frame_end) begin
                dec <= i3_n;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe <= 1'b0;
        end else begin
            strobe <= in_valid && frame_end;
        end
    end

    // Comb differences at the decimated rate, differential delay 1.
    always_comb begin
        c1 = dec - d1;
        c2 = c1 - d2;
        c3 = c2 - d3;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d1    <= '0;
            d2    <= '0;
            d3    <= '0;
            y     <= '0;
            y_vld <= 1'b0;
        end else begin
            y_vld <= strobe;
            if (strobe) begin
                d1 <= dec;
                d2 <= c1;
                d3 <= c2;
                y  <= c3;
            end
        end
    end

    // The first two decimated results see a partial window and are suppressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            warm <= '0;
        end else if (y_vld && (warm != 2'd2)) begin
            warm <= warm + 2'd1;
        end
    end

    assign load = y_vld && (warm == 2'd2);

    // Arithmetic shift floors toward -inf; only +full scale can exceed the PCM range.
    always_comb begin
        y_sh = $signed(y) >>> SH;
        if (y_sh > PCM_MAX) begin
            pcm_sat = out_bw'(PCM_MAX);
        end else if (y_sh < PCM_MIN) begin
            pcm_sat = out_bw'(PCM_MIN);
        end else begin
            pcm_sat = out_bw'(y_sh);
        end
    end

    // Holding register: a load always wins; overwriting an unaccepted sample flags overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_pcm   <= '0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
        end else if (load) begin
            out_pcm   <= pcm_sat;
            out_valid <= 1'b1;
            if (out_valid && !out_ready) begin
                ovf <= 1'b1;
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
